spi_mem_ctrl: RTL

SPI master that serves every instruction-fetch and load/store request from the rv32e core to external memory, over a single SPI bus with two chip selects.
- cs1: SPI flash (program ROM, read-only).
- cs2: SPI SRAM (data).
Sits between the core's memory request port and the top-level pins uo_out[0..3] (sclk, mosi, cs1, cs2) and ui_in[0] (miso).
Runs one request at a time, mode 0, MSB-first, using 24-bit-address 0x03 READ and 0x02 WRITE commands.

---
 rtl/spi_mem_pkg.sv | 55 +++++
 rtl/spi_shift_phy.sv | 60 ++++++
 rtl/spi_mem_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg -- shared types and constants for the SPI memory controller.
//   state_e     : controller FSM states
//   SZ_*        : request size encodings (3 decodes as word)
//   OP_*        : SPI command opcodes
//   *_BITS      : bit counts of the command, address and dummy fields
//   req_t       : request fields captured at accept
//   helpers     : data-phase bit count, write-byte ordering, read-byte ordering
package spi_mem_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sram;   // 1 = cs2 device
    logic [31:0] wdata;
  } req_t;

  function automatic logic [5:0] data_bits(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 6'd8;
      SZ_HALF: return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Byte 0 must leave first, so it goes to the top of the MSB-first shifter.
  function automatic logic [31:0] tx_data(input logic [31:0] wdata);
    return {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
  endfunction

  // The first byte received ends up highest in the shifter; undo that so
  // byte k lands at rdata[8k+7:8k], upper bytes zero.
  function automatic logic [31:0] rx_to_rdata(input logic [31:0] sr,
                                              input logic [1:0]  size);
    case (size)
      SZ_BYTE: return {24'h0, sr[7:0]};
      SZ_HALF: return {16'h0, sr[7:0], sr[15:8]};
      default: return {sr[7:0], sr[15:8], sr[23:16], sr[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_phy.sv
// spi_shift_phy -- SPI mode-0 bit engine: sclk phase, tx/rx shifters, bit counter.
//   clk, rst_n        : clock, synchronous active-low reset
//   load              : start a field; load_data is MSB-aligned, load_bits = length
//   shift             : advance one half-bit per cycle while asserted
//   clear             : stop, sclk low, mosi low (rx_data is kept)
//   miso              : serial data in, sampled on the sclk rising edge
//   sclk, mosi        : serial clock / data out (both straight from flops)
//   last_bit          : this cycle is the high phase of the field's last bit
//   rx_data           : received bits since the last load, newest in bit 0
module spi_shift_phy (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        shift,
  input  logic        clear,
  input  logic [31:0] load_data,
  input  logic [5:0]  load_bits,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        last_bit,
  output logic [31:0] rx_data
);

  logic [31:0] tx_sr;
  logic [4:0]  cnt;     // bits remaining in the field minus one

  assign mosi     = tx_sr[31];
  assign last_bit = shift & sclk & (cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk    <= 1'b0;
      tx_sr   <= '0;
      cnt     <= '0;
      rx_data <= '0;
    end else if (clear) begin
      sclk  <= 1'b0;
      tx_sr <= '0;
      cnt   <= '0;
    end else if (load) begin
      // Loading on the edge that ends the previous field's last bit keeps
      // the bit stream gapless across field boundaries.
      sclk    <= 1'b0;
      tx_sr   <= load_data;
      cnt     <= 5'(load_bits - 6'd1);
      rx_data <= '0;
    end else if (shift) begin
      if (!sclk) begin
        sclk    <= 1'b1;
        rx_data <= {rx_data[30:0], miso};
      end else begin
        sclk  <= 1'b0;
        tx_sr <= {tx_sr[30:0], 1'b0};
        cnt   <= cnt - 5'd1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl -- single-outstanding SPI master for flash (cs1) and SRAM (cs2).
//   clk, rst_n          : clock, synchronous active-low reset
//   req_*               : request port; accepted when req_valid && req_ready
//   rsp_done/rdata/err  : completion pulse, zero-extended read data, flash-write error
//   sclk, mosi, cs1, cs2: SPI pins (mode 0, MSB first, selects active low)
//   miso                : SPI data in
// Build option SPI_FAST_READ_EN: flash reads use 0x0B plus 8 dummy bits.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_BITS,
  parameter int SEL_BIT = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_done,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              sclk,
  output logic              mosi,
  output logic              cs1,
  output logic              cs2,
  input  logic              miso
);

`ifdef SPI_FAST_READ_EN
  localparam bit FAST_RD = 1'b1;
`else
  localparam bit FAST_RD = 1'b0;
`endif

  state_e            state;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic        accept, flash_wr, fast_dummy;
  logic        load, shift, clear, last_bit;
  logic [31:0] load_data, rx_data;
  logic [5:0]  load_bits;
  logic [7:0]  opcode;

  assign accept     = req_valid & req_ready;
  assign flash_wr   = req_we & ~req_addr[SEL_BIT];
  assign fast_dummy = FAST_RD & ~req_q.we & ~req_q.sram;
  assign opcode     = req_we ? OP_WRITE :
                      (FAST_RD && !req_addr[SEL_BIT]) ? OP_FAST_READ : OP_READ;
  assign shift      = (state == CMD) | (state == ADDR) | (state == DUMMY) |
                      (state == DATA);

  // Field sequencing for the bit engine; each load lands on the edge that
  // closes the previous field.
  always_comb begin
    load      = 1'b0;
    clear     = 1'b0;
    load_data = '0;
    load_bits = '0;
    case (state)
      IDLE: if (accept && !flash_wr) begin
        load      = 1'b1;
        load_data = {opcode, 24'h0};
        load_bits = 6'(CMD_BITS);
      end
      CMD: if (last_bit) begin
        load      = 1'b1;
        load_data = {addr_q, {(32-ADDR_W){1'b0}}};
        load_bits = 6'(ADDR_W);
      end
      ADDR: if (last_bit) begin
        load = 1'b1;
        if (fast_dummy) begin
          load_bits = 6'(DUMMY_BITS);
        end else begin
          load_data = req_q.we ? tx_data(req_q.wdata) : 32'h0;
          load_bits = data_bits(req_q.size);
        end
      end
      DUMMY: if (last_bit) begin
        load      = 1'b1;
        load_data = req_q.we ? tx_data(req_q.wdata) : 32'h0;
        load_bits = data_bits(req_q.size);
      end
      DATA: if (last_bit) clear = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      cs1       <= 1'b1;
      cs2       <= 1'b1;
      req_ready <= 1'b1;
      rsp_done  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_ready <= 1'b0;
          addr_q    <= req_addr;
          req_q     <= '{we: req_we, size: req_size, sram: req_addr[SEL_BIT],
                         wdata: req_wdata};
          if (flash_wr) begin
            // Flash is read-only: complete immediately without touching the bus.
            state     <= DONE;
            rsp_done  <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= CMD;
            cs1   <= req_addr[SEL_BIT];
            cs2   <= ~req_addr[SEL_BIT];
          end
        end
        CMD:   if (last_bit) state <= ADDR;
        ADDR:  if (last_bit) state <= fast_dummy ? DUMMY : DATA;
        DUMMY: if (last_bit) state <= DATA;
        DATA: if (last_bit) begin
          state     <= DONE;
          cs1       <= 1'b1;
          cs2       <= 1'b1;
          rsp_done  <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= req_q.we ? 32'h0 : rx_to_rdata(rx_data, req_q.size);
        end
        DONE: begin
          state     <= IDLE;
          rsp_done  <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_shift_phy u_phy (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .clear     (clear),
    .load_data (load_data),
    .load_bits (load_bits),
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .last_bit  (last_bit),
    .rx_data   (rx_data)
  );

endmodule
